// File: rtl/vfm_debug_pkg.sv
// Shared constants for the VFM debug blocks: opcodes, opcode classes,
// trace-buffer state encodings and the STALL instruction word.
package vfm_debug_pkg;

    // Opcodes (6-bit field at the top of the instruction word)
    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_ST   = 6'b000001;
    localparam logic [5:0] OP_CPY  = 6'b100011;
    localparam logic [5:0] OP_SWP  = 6'b100010;
    localparam logic [5:0] OP_JMP  = 6'b000100;
    localparam logic [5:0] OP_CALL = 6'b111110;
    localparam logic [5:0] OP_RET  = 6'b111101;
    localparam logic [5:0] OP_NOP  = 6'b111000;
    localparam logic [5:0] OP_CMP  = 6'b010000;
    localparam logic [5:0] OP_ADD  = 6'b101000;
    localparam logic [5:0] OP_SUB  = 6'b101001;
    localparam logic [5:0] OP_ADDC = 6'b010101;
    localparam logic [5:0] OP_SUBC = 6'b010110;
    localparam logic [5:0] OP_NOT  = 6'b100111;
    localparam logic [5:0] OP_AND  = 6'b100101;
    localparam logic [5:0] OP_OR   = 6'b100110;
    localparam logic [5:0] OP_XOR  = 6'b100100;
    localparam logic [5:0] OP_MUL  = 6'b101010;
    localparam logic [5:0] OP_DIV  = 6'b101011;
    localparam logic [5:0] OP_SH0  = 6'b010001;
    localparam logic [5:0] OP_SH1  = 6'b010010;
    localparam logic [5:0] OP_SH2  = 6'b010011;
    localparam logic [5:0] OP_SH3  = 6'b010100;
    localparam logic [5:0] OP_SH4  = 6'b011000;
    localparam logic [5:0] OP_SH5  = 6'b011001;
    localparam logic [5:0] OP_SH6  = 6'b011010;
    localparam logic [5:0] OP_SH7  = 6'b011100;
    localparam logic [5:0] OP_SH8  = 6'b011101;
    localparam logic [5:0] OP_VEC0 = 6'b110000;
    localparam logic [5:0] OP_VEC1 = 6'b110001;
    localparam logic [5:0] OP_VEC2 = 6'b110010;
    localparam logic [5:0] OP_VEC3 = 6'b110011;
    localparam logic [5:0] OP_VEC4 = 6'b111011;
    localparam logic [5:0] OP_VEC5 = 6'b111100;
    localparam logic [5:0] OP_IN   = 6'b100000;
    localparam logic [5:0] OP_OUT  = 6'b100001;

    // Opcode classes
    localparam logic [2:0] CLS_MEM   = 3'd0;
    localparam logic [2:0] CLS_MOVE  = 3'd1;
    localparam logic [2:0] CLS_CTRL  = 3'd2;
    localparam logic [2:0] CLS_ALU   = 3'd3;
    localparam logic [2:0] CLS_SHIFT = 3'd4;
    localparam logic [2:0] CLS_VEC   = 3'd5;
    localparam logic [2:0] CLS_IO    = 3'd6;
    localparam logic [2:0] CLS_UNDEF = 3'd7;

    // Trace buffer states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_POST   = 2'd2;
    localparam logic [1:0] ST_FROZEN = 2'd3;

    // All-ones IR marks a pipeline stall (width-independent fill value)
    localparam logic STALL_BIT = 1'b1;

endpackage

// File: rtl/vfm_opcode_class.sv
// Combinational opcode-to-class lookup, shared with the IR-to-ASCII decoder.
module vfm_opcode_class
    import vfm_debug_pkg::*;
(
    input  logic [5:0] opc_i,
    output logic [2:0] cls_o
);

    // Classify the opcode; anything not listed is undefined
    always_comb begin
        cls_o = CLS_UNDEF;
        case (opc_i)
            OP_LD, OP_ST:                                     cls_o = CLS_MEM;
            OP_CPY, OP_SWP:                                   cls_o = CLS_MOVE;
            OP_JMP, OP_CALL, OP_RET, OP_NOP, OP_CMP:          cls_o = CLS_CTRL;
            OP_ADD, OP_SUB, OP_ADDC, OP_SUBC, OP_NOT,
            OP_AND, OP_OR, OP_XOR, OP_MUL, OP_DIV:            cls_o = CLS_ALU;
            OP_SH0, OP_SH1, OP_SH2, OP_SH3, OP_SH4,
            OP_SH5, OP_SH6, OP_SH7, OP_SH8:                   cls_o = CLS_SHIFT;
            OP_VEC0, OP_VEC1, OP_VEC2, OP_VEC3,
            OP_VEC4, OP_VEC5:                                 cls_o = CLS_VEC;
            OP_IN, OP_OUT:                                    cls_o = CLS_IO;
            default:                                          cls_o = CLS_UNDEF;
        endcase
    end

endmodule

// File: rtl/vfm_itrace_buffer.sv
// Instruction trace buffer: records issued non-stall IR words with a cycle
// stamp into a circular buffer, freezes POST_TRIG captures after a trigger,
// then drains oldest-first over a valid/ready port.
module vfm_itrace_buffer
    import vfm_debug_pkg::*;
#(
    parameter int IW_WIDTH    = 16,
    parameter int OPC_WIDTH   = 6,
    parameter int DEPTH       = 16,
    parameter int STAMP_WIDTH = 16,
    parameter int POST_TRIG   = 8
) (
    input  logic                       Clock_pin,
    input  logic                       Reset_pin,
    input  logic                       IR_valid,
    input  logic [IW_WIDTH-1:0]        IR,
    input  logic                       Arm,
    input  logic                       Trig_en,
    input  logic [OPC_WIDTH-1:0]       Trig_opc,
    input  logic                       Force_trig,
    input  logic                       Rd_ready,
    output logic                       Rd_valid,
    output logic [IW_WIDTH-1:0]        Rd_ir,
    output logic [STAMP_WIDTH-1:0]     Rd_stamp,
    output logic [2:0]                 Rd_class,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Overflow,
    output logic [1:0]                 State
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = IW_WIDTH + STAMP_WIDTH + 3;

    logic [EW-1:0]          mem_q [DEPTH];
    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          post_q, post_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [STAMP_WIDTH-1:0] stamp_q;
    logic                   ovf_q, ovf_d;

    logic                   cap, trig, we, clr;
    logic [OPC_WIDTH-1:0]   opc;
    logic [2:0]             cls;

    assign opc  = IR[IW_WIDTH-1 -: OPC_WIDTH];
    assign cap  = IR_valid && (IR != {IW_WIDTH{STALL_BIT}});
    assign trig = Force_trig || (Trig_en && cap && (opc == Trig_opc));

    vfm_opcode_class u_cls (
        .opc_i (6'(opc)),
        .cls_o (cls)
    );

    // Next-state: capture/trigger sequencing, drain, and buffer bookkeeping
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        post_d   = post_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        we       = 1'b0;
        clr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Arm) begin
                    state_d = ST_ARMED;
                    clr     = 1'b1;
                end
            end
            ST_ARMED: begin
                if (Arm) begin
                    clr = 1'b1;
                end else begin
                    we = cap;
                    if (trig) begin
                        if (POST_TRIG == 0) begin
                            state_d = ST_FROZEN;
                        end else begin
                            state_d = ST_POST;
                            post_d  = CW'(POST_TRIG);
                        end
                    end
                end
            end
            ST_POST: begin
                if (Arm) begin
                    state_d = ST_ARMED;
                    clr     = 1'b1;
                end else if (cap) begin
                    we     = 1'b1;
                    post_d = post_q - CW'(1);
                    if (post_q == CW'(1)) state_d = ST_FROZEN;
                end
            end
            default: begin // ST_FROZEN
                if (Arm) begin
                    state_d = ST_ARMED;
                    clr     = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else if (Rd_ready) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    cnt_d    = cnt_q - CW'(1);
                end
            end
        endcase

        if (clr) begin
            cnt_d    = '0;
            post_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end

        // A write into a full buffer drops the oldest entry
        if (we) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (cnt_q == CW'(DEPTH)) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                ovf_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Control registers with synchronous reset; stamp runs every cycle
    always_ff @(posedge Clock_pin) begin
        if (Reset_pin) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            post_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            stamp_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            post_q   <= post_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            stamp_q  <= stamp_q + STAMP_WIDTH'(1);
        end
    end

    // Entry storage; contents are don't-care until written after Arm
    always_ff @(posedge Clock_pin) begin
        if (!Reset_pin && we) mem_q[wr_ptr_q] <= {IR, stamp_q, cls};
    end

    assign {Rd_ir, Rd_stamp, Rd_class} = mem_q[rd_ptr_q];
    assign Rd_valid = (state_q == ST_FROZEN) && (cnt_q != '0);
    assign Count    = cnt_q;
    assign Overflow = ovf_q;
    assign State    = state_q;

endmodule

// File: tb/tb_vfm_itrace_buffer.sv
// Randomized + directed bench for vfm_itrace_buffer. Two instances
// (POST_TRIG=0 and 8) share the stimulus; each is compared every cycle
// against a queue-based reference model.
module tb_vfm_itrace_buffer;

    localparam int DEPTH = 16;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] st;
        logic [2:0]  cl;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, irv, arm, ten, frc, rdy;
    logic [15:0] ir;
    logic [5:0]  topc;

    logic [1:0]  rv, ovf;
    logic [15:0] rir [2];
    logic [15:0] rst_stamp [2];
    logic [2:0]  rcl [2];
    logic [4:0]  cnt [2];
    logic [1:0]  st [2];

    int nchk = 0;
    int nerr = 0;

    // reference model state
    int          m_state [2];
    int          m_left  [2];
    bit          m_ovf   [2];
    ent_t        mq0 [$];
    ent_t        mq1 [$];
    logic [15:0] m_stamp;
    int          pt [2] = '{0, 8};

    always #5 clk = ~clk;

    vfm_itrace_buffer #(.IW_WIDTH(16), .OPC_WIDTH(6), .DEPTH(DEPTH), .STAMP_WIDTH(16), .POST_TRIG(0)) u_p0 (
        .Clock_pin(clk), .Reset_pin(rst), .IR_valid(irv), .IR(ir), .Arm(arm),
        .Trig_en(ten), .Trig_opc(topc), .Force_trig(frc), .Rd_ready(rdy),
        .Rd_valid(rv[0]), .Rd_ir(rir[0]), .Rd_stamp(rst_stamp[0]), .Rd_class(rcl[0]),
        .Count(cnt[0]), .Overflow(ovf[0]), .State(st[0]));

    vfm_itrace_buffer #(.IW_WIDTH(16), .OPC_WIDTH(6), .DEPTH(DEPTH), .STAMP_WIDTH(16), .POST_TRIG(8)) u_p8 (
        .Clock_pin(clk), .Reset_pin(rst), .IR_valid(irv), .IR(ir), .Arm(arm),
        .Trig_en(ten), .Trig_opc(topc), .Force_trig(frc), .Rd_ready(rdy),
        .Rd_valid(rv[1]), .Rd_ir(rir[1]), .Rd_stamp(rst_stamp[1]), .Rd_class(rcl[1]),
        .Count(cnt[1]), .Overflow(ovf[1]), .State(st[1]));

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // class table straight from the opcode listing
    function automatic logic [2:0] klass(logic [5:0] o);
        if (o inside {6'b000000, 6'b000001}) return 3'd0;
        if (o inside {6'b100011, 6'b100010}) return 3'd1;
        if (o inside {6'b000100, 6'b111110, 6'b111101, 6'b111000, 6'b010000}) return 3'd2;
        if (o inside {6'b101000, 6'b101001, 6'b010101, 6'b010110, 6'b100111,
                      6'b100101, 6'b100110, 6'b100100, 6'b101010, 6'b101011}) return 3'd3;
        if (o inside {6'b010001, 6'b010010, 6'b010011, 6'b010100, 6'b011000,
                      6'b011001, 6'b011010, 6'b011100, 6'b011101}) return 3'd4;
        if (o inside {6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b111011, 6'b111100}) return 3'd5;
        if (o inside {6'b100000, 6'b100001}) return 3'd6;
        return 3'd7;
    endfunction

    function automatic int qsize(int i);
        return (i == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic ent_t qhead(int i);
        return (i == 0) ? mq0[0] : mq1[0];
    endfunction

    task automatic qclear(int i);
        if (i == 0) mq0.delete(); else mq1.delete();
        m_ovf[i] = 1'b0;
    endtask

    task automatic qpop(int i);
        if (i == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
    endtask

    task automatic qpush(int i, ent_t e);
        if (qsize(i) == DEPTH) begin
            qpop(i);
            m_ovf[i] = 1'b1;
        end
        if (i == 0) mq0.push_back(e); else mq1.push_back(e);
    endtask

    // advance the model by one clock edge using the current inputs
    task automatic model_upd();
        bit   cap, trg;
        ent_t e;
        cap  = irv && (ir != 16'hFFFF);
        trg  = frc || (ten && cap && ir[15:10] == topc);
        e.ir = ir; e.st = m_stamp; e.cl = klass(ir[15:10]);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_state[i] = 0; m_left[i] = 0; qclear(i);
            end else if (arm && m_state[i] != 0) begin
                m_state[i] = 1; qclear(i);
            end else begin
                case (m_state[i])
                    0: if (arm) begin m_state[i] = 1; qclear(i); end
                    1: begin
                        if (cap) qpush(i, e);
                        if (trg) begin
                            if (pt[i] == 0) m_state[i] = 3;
                            else begin m_state[i] = 2; m_left[i] = pt[i]; end
                        end
                    end
                    2: if (cap) begin
                        qpush(i, e);
                        m_left[i]--;
                        if (m_left[i] == 0) m_state[i] = 3;
                    end
                    default: begin
                        if (qsize(i) == 0) m_state[i] = 0;
                        else if (rdy) qpop(i);
                    end
                endcase
            end
        end
        m_stamp = rst ? 16'd0 : m_stamp + 16'd1;
    endtask

    task automatic check_all();
        ent_t h;
        bit   v;
        for (int i = 0; i < 2; i++) begin
            v = (m_state[i] == 3) && (qsize(i) != 0);
            chk($sformatf("p%0d_state", i), 32'(st[i]), 32'(m_state[i]));
            chk($sformatf("p%0d_count", i), 32'(cnt[i]), 32'(qsize(i)));
            chk($sformatf("p%0d_ovf", i), 32'(ovf[i]), 32'(m_ovf[i]));
            chk($sformatf("p%0d_rvalid", i), 32'(rv[i]), 32'(v));
            if (v) begin
                h = qhead(i);
                chk($sformatf("p%0d_rd_ir", i), 32'(rir[i]), 32'(h.ir));
                chk($sformatf("p%0d_rd_stamp", i), 32'(rst_stamp[i]), 32'(h.st));
                chk($sformatf("p%0d_rd_class", i), 32'(rcl[i]), 32'(h.cl));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_upd();
        @(negedge clk);
        check_all();
    endtask

    task automatic cyc(logic v, logic [15:0] w, logic a, logic f, logic r);
        irv = v; ir = w; arm = a; frc = f; rdy = r;
        step();
        arm = 1'b0; frc = 1'b0;
    endtask

    task automatic idle(int n, logic r);
        for (int k = 0; k < n; k++) cyc(1'b0, 16'h0, 1'b0, 1'b0, r);
    endtask

    logic [5:0] opl [16] = '{6'b000000, 6'b000001, 6'b100011, 6'b000100, 6'b111110,
                             6'b101000, 6'b010101, 6'b100100, 6'b010001, 6'b011101,
                             6'b110000, 6'b111100, 6'b100000, 6'b100001, 6'b000111,
                             6'b010000};

    initial begin
        rst = 1'b1; irv = 1'b0; ir = '0; arm = 1'b0; ten = 1'b0; frc = 1'b0;
        rdy = 1'b0; topc = '0; m_stamp = '0;
        for (int i = 0; i < 2; i++) begin m_state[i] = 0; m_left[i] = 0; m_ovf[i] = 0; end
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_state", 32'(st[i]), 32'd0);
            chk("rst_count", 32'(cnt[i]), 32'd0);
            chk("rst_rvalid", 32'(rv[i]), 32'd0);
        end

        // LD x3, forced trigger on the last one, then drain
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h0001, 1'b0, 1'b1, 1'b0);
        chk("s1_frozen", 32'(st[0]), 32'd3);
        chk("s1_count3", 32'(cnt[0]), 32'd3);
        chk("s1_class_mem", 32'(rcl[0]), 32'd0);
        idle(6, 1'b1);
        chk("s1_idle", 32'(st[0]), 32'd0);

        // 20 distinct ADD words, overflow, then forced trigger
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) cyc(1'b1, 16'hA000 | 16'(k), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("s2_ovf", 32'(ovf[0]), 32'd1);
        chk("s2_count16", 32'(cnt[0]), 32'd16);
        chk("s2_oldest", 32'(rir[0]), 32'hA005);
        for (int k = 21; k <= 28; k++) cyc(1'b1, 16'hA000 | 16'(k), 1'b0, 1'b0, 1'b1);
        idle(20, 1'b1);

        // JMP opcode trigger with 8 post captures
        ten = 1'b1; topc = 6'b000100;
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++)
            cyc(1'b1, (k == 10) ? 16'h1234 : (16'hA400 | 16'(k)), 1'b0, 1'b0, 1'b0);
        chk("s3_p8_frozen", 32'(st[1]), 32'd3);
        chk("s3_p8_count", 32'(cnt[1]), 32'd16);
        idle(20, 1'b1);
        ten = 1'b0;

        // stalls interleaved while armed
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++)
            cyc(1'b1, (k % 2) ? 16'hFFFF : (16'h5400 | 16'(k)), 1'b0, 1'b0, 1'b0);
        chk("s4_no_stall", 32'(cnt[0]), 32'd5);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        idle(8, 1'b1);

        // reset during POST with count 9
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) cyc(1'b1, 16'h6000 | 16'(k), 1'b0, k == 5, 1'b0);
        chk("s5_post", 32'(st[1]), 32'd2);
        chk("s5_cnt9", 32'(cnt[1]), 32'd9);
        rst = 1'b1; step(); rst = 1'b0;
        chk("s5_rst_state", 32'(st[1]), 32'd0);
        chk("s5_rst_cnt", 32'(cnt[1]), 32'd0);

        // reset mid-drain with overflow set
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 18; k++) cyc(1'b1, 16'h7000 | 16'(k), 1'b0, k == 17, 1'b0);
        idle(3, 1'b1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("s5b_state", 32'(st[0]), 32'd0);
        chk("s5b_ovf", 32'(ovf[0]), 32'd0);
        chk("s5b_rvalid", 32'(rv[0]), 32'd0);

        // undefined opcode class
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h1C05, 1'b0, 1'b1, 1'b0);
        chk("s6_undef_cls", 32'(rcl[0]), 32'd7);
        idle(4, 1'b1);

        // random soak
        for (int k = 0; k < 3000; k++) begin
            logic [15:0] w;
            w = {opl[$urandom_range(0, 15)], 10'($urandom)};
            if ($urandom_range(0, 9) == 0) w = 16'hFFFF;
            if ($urandom_range(0, 99) == 0) begin
                ten = 1'($urandom); topc = opl[$urandom_range(0, 15)];
            end
            rst = ($urandom_range(0, 399) == 0);
            cyc(1'($urandom_range(0, 9) < 7), w, $urandom_range(0, 79) == 0,
                $urandom_range(0, 49) == 0, 1'($urandom));
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/vfm_itrace_buffer.md
Name: vfm_itrace_buffer

Overview:
Debug-only instruction trace capture block for the VFM core, the sequential successor to the IR-to-ASCII decoder. It records every issued, non-stall instruction word with a cycle stamp into a parametrised circular buffer. On a programmable opcode trigger it captures a fixed number of post-trigger entries and then freezes. The frozen trace is then drained oldest-first over a valid/ready port, with each entry tagged by an opcode class. It sits beside the CU on the IR bus and is excluded from FPGA synthesis builds.

Parameters:
IW_WIDTH, 16, instruction word width; opcode is IR[IW_WIDTH-1 -: OPC_WIDTH]
OPC_WIDTH, 6, opcode field width
DEPTH, 16, buffer entries; power of two, >= 2
STAMP_WIDTH, 16, cycle-stamp counter width
POST_TRIG, 8, entries captured after the trigger entry; 0 <= POST_TRIG <= DEPTH-1

Ports:
Clock_pin  in  1  single clock, rising edge
Reset_pin  in  1  synchronous, active-high reset
IR_valid  in  1  IR holds a newly issued instruction this cycle
IR  in  IW_WIDTH  instruction word
Arm  in  1  single-cycle pulse: clear buffer and start recording
Trig_en  in  1  enable opcode match trigger
Trig_opc  in  OPC_WIDTH  opcode that fires the trigger
Force_trig  in  1  single-cycle pulse: immediate trigger
Rd_ready  in  1  consumer accepts current entry
Rd_valid  out  1  entry available
Rd_ir  out  IW_WIDTH  oldest entry instruction word
Rd_stamp  out  STAMP_WIDTH  cycle stamp of that entry
Rd_class  out  3  opcode class of that entry
Count  out  $clog2(DEPTH)+1  entries held
Overflow  out  1  sticky: an entry was overwritten since the last Arm
State  out  2  IDLE=0, ARMED=1, POST=2, FROZEN=3

Behaviour:
- Reset is synchronous and active-high. It has priority over every other input, including mid-capture and mid-drain.
- On reset: State=IDLE, Count=0, Overflow=0, write and read pointers=0, post counter=0, stamp=0, Rd_valid=0.
- Stamp: a free-running counter that increments every cycle and wraps modulo 2^STAMP_WIDTH. A captured entry stores the stamp value of its capture cycle.
- Capture qualifier: cap = IR_valid && (IR != all-ones). An all-ones IR is a STALL and is never recorded.
- Writes occur only in ARMED or POST. A write stores {IR, stamp, class} at wr_ptr, and wr_ptr increments modulo DEPTH.
- If Count==DEPTH on a write, the oldest entry is overwritten: rd_ptr advances, Count is held, and Overflow is set.
- IDLE:
  - Arm -> ARMED. On the same edge, Count, pointers and Overflow are cleared.
  - All other inputs are ignored.
- ARMED:
  - trig = Force_trig || (Trig_en && cap && opcode==Trig_opc).
  - The trigger entry is itself recorded whenever cap is true.
  - On trig: if POST_TRIG==0 -> FROZEN, otherwise -> POST with post counter loaded to POST_TRIG.
  - Arm re-clears the buffer and stays in ARMED.
- POST:
  - Each cap write decrements the post counter. The write that makes it 0 moves the state to FROZEN on the same edge.
  - Further triggers are ignored.
  - Arm re-clears the buffer and returns to ARMED.
- FROZEN:
  - Nothing is written. Rd_valid = (Count != 0).
  - Rd_ir, Rd_stamp and Rd_class are driven combinationally from the entry at rd_ptr.
  - A transfer occurs when Rd_valid && Rd_ready. On a transfer, rd_ptr increments modulo DEPTH and Count decrements.
  - When Count reaches 0 (including when frozen empty), the state moves to IDLE on the next edge.
  - Arm in FROZEN discards the remaining entries and goes to ARMED.
- Rd_valid is 0 in every state other than FROZEN. Rd_* data are don't-care while Rd_valid=0.
- Rd_class encoding:
  - 0 = MEM: LD 000000, ST 000001
  - 1 = MOVE: CPY 100011, SWP 100010
  - 2 = CTRL: JMP 000100, CALL 111110, RET 111101, NOP 111000, CMP 010000
  - 3 = ALU: ADD 101000, SUB 101001, ADDC 010101, SUBC 010110, NOT 100111, AND 100101, OR 100110, XOR 100100, MUL 101010, DIV 101011
  - 4 = SHIFT: 010001, 010010, 010011, 010100, 011000, 011001, 011010, 011100, 011101
  - 5 = VECTOR: 110000, 110001, 110010, 110011, 111011, 111100
  - 6 = IO: IN 100000, OUT 100001
  - 7 = undefined opcode
- The class is computed at capture and stored with the entry.

Decomposition:
- Package vfm_debug_pkg holds:
  - opcode localparams for all defined opcodes
  - class codes CLS_MEM..CLS_UNDEF
  - state encodings
  - the STALL word constant
- One natural sub-module: vfm_opcode_class, a combinational opcode-to-class lookup. The IR-to-ASCII decoder can reuse it later.
- Storage is a plain register array of DEPTH entries, each IW_WIDTH+STAMP_WIDTH+3 bits wide.

Test Plan:
- Reset then Arm; feed IR=0x0001 (LD) at stamps 5..7 with Force_trig at stamp 7 and POST_TRIG=0 -> State=FROZEN, Count=3. Drain with Rd_ready=1 returns IR 0x0001 at stamps 5, 6, 7 with Rd_class=0, then State=IDLE.
- DEPTH=16: Arm, feed 20 distinct ADD words (opcode 101000), no trigger, then Force_trig -> Overflow=1, Count=16. Drain returns words 5..20 in order, each with Rd_class=3.
- Trig_en=1, Trig_opc=000100, POST_TRIG=8; stream ALU words and insert JMP at position 10 -> freeze 8 captures after the JMP. The JMP entry is present with class 2, and State moves to FROZEN on the 8th post-trigger write.
- Interleave IR=0xFFFF with IR_valid=1 during ARMED -> no 0xFFFF entries are recorded and Count excludes them.
- Assert Reset_pin during POST with Count=9, and again during FROZEN mid-drain -> next cycle State=IDLE, Count=0, Rd_valid=0, Overflow=0.
- Opcode 000111 (undefined) captured -> Rd_class=7. Toggle Rd_ready at 50% during drain -> no entry is lost or duplicated, and the stamp order is monotonic modulo wrap.
